// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one sequential GCD engine among four
// requesters, short-circuits zero operands and aborts stuck engine runs with a watchdog.
module gcd_arbiter #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req_valid,
   output logic [3:0]         req_ready,
   input  logic [4*WIDTH-1:0] req_a,
   input  logic [4*WIDTH-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [1:0]         rsp_id,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_err,
   output logic               eng_load,
   output logic [WIDTH-1:0]   eng_a,
   output logic [WIDTH-1:0]   eng_b,
   input  logic               eng_done,
   input  logic [WIDTH-1:0]   eng_c,
   output logic [15:0]        done_count
);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [1:0]       rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic             eng_load_q, eng_load_d;
   logic [WIDTH-1:0] eng_a_q, eng_a_d;
   logic [WIDTH-1:0] eng_b_q, eng_b_d;
   logic [15:0]      done_count_q, done_count_d;
   logic [1:0]       win;
   logic             found;
   logic [WIDTH-1:0] a, b;

   // Search starts just past the last grant, so a requester holding valid waits its turn.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= 4; k++) begin
         if (!found && req_valid[ptr_q + 2'(k)]) begin
            found = 1'b1;
            win   = ptr_q + 2'(k);
         end
      end
   end

   assign req_ready = (state_q == IDLE && found) ? 4'b0001 << win : 4'b0000;
   assign a = req_a[win*WIDTH +: WIDTH];
   assign b = req_b[win*WIDTH +: WIDTH];

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      timer_d      = timer_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      eng_load_d   = 1'b0;
      eng_a_d      = eng_a_q;
      eng_b_d      = eng_b_q;
      done_count_d = done_count_q;
      case (state_q)
         IDLE: if (found) begin
            ptr_d    = win;
            rsp_id_d = win;
            if (a == '0 || b == '0) begin
               rsp_data_d  = a | b;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               eng_a_d    = a;
               eng_b_d    = b;
               eng_load_d = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         // A done pulse in the final watchdog cycle still counts as success.
         WAIT: begin
            timer_d = timer_q + 1'b1;
            if (eng_done) begin
               rsp_data_d  = eng_c;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         default: if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
            done_count_d = done_count_q + 16'd1;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 2'd3;
         timer_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         eng_load_q   <= 1'b0;
         eng_a_q      <= '0;
         eng_b_q      <= '0;
         done_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         timer_q      <= timer_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         eng_load_q   <= eng_load_d;
         eng_a_q      <= eng_a_d;
         eng_b_q      <= eng_b_d;
         done_count_q <= done_count_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign eng_load   = eng_load_q;
   assign eng_a      = eng_a_q;
   assign eng_b      = eng_b_q;
   assign done_count = done_count_q;
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed plus randomized transactions against a cycle-level reference
// model of the arbiter; a behavioural engine answers loads after a chosen latency.
module tb_gcd_arbiter;
   localparam int W  = 8;
   localparam int TO = 8;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [4*W-1:0] req_a, req_b;
   logic         rsp_valid, rsp_ready, rsp_err;
   logic [1:0]   rsp_id;
   logic [W-1:0] rsp_data, eng_a, eng_b, eng_c;
   logic         eng_load, eng_done;
   logic [15:0]  done_count;
   int checks = 0, failures = 0;
   int mptr, mdone, loads = 0, eng_lat = 0, ecnt = 0;
   bit pend = 0, stale = 0;
   logic [W-1:0] ea, eb;
   logic [W-1:0] op_a [4], op_b [4];

   gcd_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_load(eng_load),
      .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_c(eng_c),
      .done_count(done_count)
   );

   always #5 clk = ~clk;

   function automatic int ref_gcd(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int next_grant(input logic [3:0] m, input int p);
      for (int k = 1; k <= 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Engine: answers lat cycles after its load cycle; lat 0 means it never answers.
   always @(negedge clk) begin
      eng_done = 1'b0;
      if (eng_load) begin
         loads++;
         ea   = eng_a;
         eb   = eng_b;
         ecnt = eng_lat;
         pend = eng_lat > 0;
         if (stale) begin
            eng_done = 1'b1;
            eng_c    = 8'hFF;
         end
      end else if (pend) begin
         ecnt--;
         if (ecnt == 0) begin
            eng_done = 1'b1;
            eng_c    = W'(ref_gcd(ea, eb));
            pend     = 1'b0;
         end
      end
   end

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[i] = a;
      op_b[i] = b;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_rspv"}, {rsp_valid, rsp_err, eng_load}, 0);
      chk({tag, "_rsp"}, {rsp_id, rsp_data}, 0);
      chk({tag, "_eng"}, {eng_a, eng_b}, 0);
      chk({tag, "_cnt"}, done_count, 0);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      #1;
      reset_checks("rst");
      step;
      step;
      rst_n = 1'b1;
      mptr  = 3;
      mdone = 0;
   endtask

   // One complete transaction, starting with the request(s) already presented.
   task automatic serve(input int lat, input int hold, input bit keep);
      int n, g, l0, exp_n;
      logic [W-1:0] a, b, xd;
      bit xe, zero;
      eng_lat   = lat;
      rsp_ready = (hold == 0);
      #1;
      n = 0;
      while (!(|(req_ready & req_valid)) && n < 50) begin
         step;
         n++;
      end
      if (n >= 50) begin
         chk("grant_timeout", n, 0);
         return;
      end
      g = next_grant(req_valid, mptr);
      chk("grant", req_ready, 4'b0001 << g);
      a = op_a[g];
      b = op_b[g];
      step;
      l0 = loads;
      if (!keep) req_valid[g] = 1'b0;
      mptr = g;
      zero = (a == 0 || b == 0);
      if (zero) begin
         xd = a | b;
         xe = 1'b0;
         chk("zero_rsp", {rsp_valid, eng_load}, 2'b10);
      end else begin
         chk("load", {eng_load, eng_a, eng_b}, {1'b1, a, b});
         xe    = (lat == 0);
         xd    = xe ? '0 : W'(ref_gcd(a, b));
         exp_n = xe ? TO + 1 : lat + 1;
         n = 0;
         while (!rsp_valid && n < 100) begin
            step;
            n++;
         end
         chk("rsp_lat", n, exp_n);
         chk("eng_hold", {eng_a, eng_b}, {a, b});
      end
      chk("rsp_id", rsp_id, g);
      chk("rsp_data", rsp_data, xd);
      chk("rsp_err", rsp_err, xe);
      for (int i = 0; i < hold; i++) begin
         step;
         chk("bp_hold", {rsp_valid, rsp_err, rsp_id, rsp_data, req_ready}, {1'b1, xe, 2'(g), xd, 4'b0});
      end
      rsp_ready = 1'b1;
      step;
      mdone = (mdone + 1) % 65536;
      chk("rsp_drop", rsp_valid, 0);
      chk("done_cnt", done_count, mdone);
      chk("load_cnt", loads - l0, zero ? 0 : 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit bad;
      logic [3:0] mask;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      eng_done  = 1'b0;
      eng_c     = '0;
      do_reset;
      set_req(0, 12, 18);
      serve(3, 0, 0);
      chk("single_cnt", done_count, 1);
      do_reset;
      set_req(0, 8, 12);
      set_req(1, 9, 6);
      set_req(2, 10, 15);
      set_req(3, 14, 21);
      repeat (5) serve(3, 0, 1);
      req_valid = '0;
      set_req(2, 0, 9);
      serve(3, 0, 0);
      set_req(2, 0, 0);
      serve(3, 0, 0);
      set_req(1, 100, 75);
      serve(0, 0, 0);
      set_req(1, 100, 75);
      serve(2, 0, 0);
      stale = 1'b1;
      set_req(3, 48, 36);
      serve(3, 0, 0);
      stale = 1'b0;
      set_req(3, 27, 18);
      set_req(1, 0, 5);
      serve(2, 5, 0);
      serve(2, 5, 0);
      set_req(1, 20, 30);
      eng_lat = 6;
      #1;
      chk("rw_grant", req_ready, 4'b0010);
      step;
      req_valid = '0;
      chk("rw_load", eng_load, 1);
      step;
      step;
      rst_n = 1'b0;
      #1;
      reset_checks("rw");
      chk("rw_ready", req_ready, 0);
      step;
      rst_n = 1'b1;
      mptr  = 3;
      mdone = 0;
      bad   = 1'b0;
      repeat (8) begin
         step;
         if (rsp_valid || eng_load) bad = 1'b1;
      end
      chk("rw_norsp", bad, 0);
      chk("rw_cnt", done_count, 0);
      repeat (30) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++)
            if (mask[i])
               set_req(i, ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255)),
                          ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255)));
         for (int t = 0; t < 8 && req_valid != 0; t++) begin
            stale = ($urandom_range(0, 3) == 0);
            serve(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6), $urandom_range(0, 3), 0);
         end
         stale     = 1'b0;
         req_valid = '0;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
